// File: rtl/stepped_core_pkg.sv
// Shared definitions for stepped_core: opcodes, FSM state encoding and
// instruction field widths.
package stepped_core_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_SQR  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_LDA  = 4'h8;
    localparam logic [3:0] OP_LDB  = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    function automatic int rsel_width(input int nregs);
        return $clog2(nregs);
    endfunction

    function automatic int instr_width(input int nregs);
        return OPCODE_W + 2 * $clog2(nregs);
    endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU for the arithmetic/shift opcodes (0..6); other opcodes
// yield zero with carry clear.
module core_alu
    import stepped_core_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] sq;

    // The extra top bit of diff is the borrow (set when a < b).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign sq   = {{WIDTH{1'b0}}, b} * {{WIDTH{1'b0}}, b};

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SUB: begin
                y     = diff[WIDTH-1:0];
                carry = diff[WIDTH];
            end
            OP_MUL: begin
                y     = prod[WIDTH-1:0];
                carry = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                if (b == '0) begin
                    y     = '1;
                    carry = 1'b1;
                end else begin
                    y     = a / b;
                    carry = 1'b0;
                end
            end
            OP_SHL: begin
                y     = {a[WIDTH-2:0], 1'b0};
                carry = a[WIDTH-1];
            end
            OP_SHR: begin
                y     = {1'b0, a[WIDTH-1:1]};
                carry = a[0];
            end
            OP_SQR: begin
                y     = sq[WIDTH-1:0];
                carry = |sq[2*WIDTH-1:WIDTH];
            end
            default: begin
                y     = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/stepped_core.sv
// Multicycle core: IDLE/FETCH/EXEC/HALT sequencer, program counter and
// register file around core_alu, driven by single steps or free-run.
module stepped_core
    import stepped_core_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NREGS   = 4,
    parameter  int PC_W    = 8,
    localparam int RSEL_W  = $clog2(NREGS),
    localparam int INSTR_W = OPCODE_W + 2 * RSEL_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic               step,
    input  logic               restart,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               carry,
    output logic               halted,
    output logic [1:0]         state
);

    state_t             st;
    logic [INSTR_W-1:0] ir;
    logic [WIDTH-1:0]   regs [NREGS];

    logic [3:0]         opcode;
    logic [RSEL_W-1:0]  rd;
    logic [RSEL_W-1:0]  rs;
    logic [WIDTH-1:0]   rd_val;
    logic [WIDTH-1:0]   rs_val;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_c;
    logic [PC_W-1:0]    jmp_target;

    assign opcode     = ir[INSTR_W-1 -: OPCODE_W];
    assign rd         = ir[2*RSEL_W-1 -: RSEL_W];
    assign rs         = ir[RSEL_W-1:0];
    assign rd_val     = regs[rd];
    assign rs_val     = regs[rs];
    assign jmp_target = PC_W'(ir[2*RSEL_W-1:0]);
    assign state      = st;

    core_alu #(.WIDTH(WIDTH)) u_alu (
        .a     (rd_val),
        .b     (rs_val),
        .op    (opcode),
        .y     (alu_y),
        .carry (alu_c)
    );

    // Output handshake: out_valid is a one-cycle strobe with no back-pressure;
    // out_data is valid in that cycle and holds until the next OUT or restart.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= ST_IDLE;
            pc        <= '0;
            ir        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            carry     <= 1'b0;
            halted    <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (restart) begin
                st       <= ST_IDLE;
                pc       <= '0;
                ir       <= '0;
                out_data <= '0;
                carry    <= 1'b0;
                halted   <= 1'b0;
                for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (step || run) st <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        ir <= instr;
                        pc <= pc + PC_W'(1);
                        st <= ST_EXEC;
                    end
                    ST_EXEC: begin
                        // run is re-sampled here, so dropping it mid-instruction
                        // lets the current instruction finish first.
                        st <= run ? ST_FETCH : ST_IDLE;
                        case (opcode)
                            OP_ADD, OP_SUB, OP_MUL, OP_DIV,
                            OP_SHL, OP_SHR, OP_SQR: begin
                                regs[rd] <= alu_y;
                                carry    <= alu_c;
                            end
                            OP_MOV: regs[rd] <= rs_val;
                            OP_LDA: regs[rd] <= in_a;
                            OP_LDB: regs[rd] <= in_b;
                            OP_OUT: begin
                                out_data  <= rs_val;
                                out_valid <= 1'b1;
                            end
                            OP_JMP: pc <= jmp_target;
                            OP_HALT: begin
                                st     <= ST_HALT;
                                halted <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    ST_HALT: ;
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stepped_core.sv
// Self-checking bench for stepped_core: directed corner sequences, an ALU
// vector table and a randomized program checked against an arithmetic model.
module tb_stepped_core;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic       step;
    logic       restart;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] pc;
    logic [7:0] instr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       carry;
    logic       halted;
    logic [1:0] state;

    logic [7:0] rom [256];
    assign instr = rom[pc];

    int n_vec = 0;
    int n_err = 0;

    // model state
    int m_r [4];
    int m_pc, m_carry, m_out, m_ov;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op_instr;
        logic [7:0] exp_y;
        logic       exp_c;
    } alu_vec_t;
    alu_vec_t vecs [12];

    stepped_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .step      (step),
        .restart   (restart),
        .in_a      (in_a),
        .in_b      (in_b),
        .pc        (pc),
        .instr     (instr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .carry     (carry),
        .halted    (halted),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
    endtask

    task automatic restart_core();
        @(posedge clk); #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
    endtask

    // One step pulse; waits for IDLE/HALT and counts out_valid cycles seen.
    task automatic step_one(output int ov_cnt, output bit ok);
        ov_cnt = 0;
        ok     = 1'b0;
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) ov_cnt++;
            if (state == 2'd0 || state == 2'd3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        m_pc = 0; m_carry = 0; m_out = 0; m_ov = 0;
    endtask

    // Architectural effect of one instruction, from the opcode table.
    task automatic model_step(input int a_in, input int b_in);
        int ins, op, rd, rs, a, b, t;
        ins = int'(rom[m_pc]);
        op  = ins / 16;
        rd  = (ins / 4) % 4;
        rs  = ins % 4;
        a   = m_r[rd];
        b   = m_r[rs];
        m_pc = (m_pc + 1) % 256;
        m_ov = 0;
        case (op)
            0: begin t = a + b; m_r[rd] = t % 256; m_carry = (t > 255); end
            1: begin m_r[rd] = (a - b + 256) % 256; m_carry = (a < b); end
            2: begin t = a * b; m_r[rd] = t % 256; m_carry = (t > 255); end
            3: begin
                if (b == 0) begin m_r[rd] = 255; m_carry = 1; end
                else begin m_r[rd] = a / b; m_carry = 0; end
            end
            4: begin t = a * 2; m_r[rd] = t % 256; m_carry = (t > 255); end
            5: begin m_r[rd] = a / 2; m_carry = a % 2; end
            6: begin t = b * b; m_r[rd] = t % 256; m_carry = (t > 255); end
            7: m_r[rd] = b;
            8: m_r[rd] = a_in;
            9: m_r[rd] = b_in;
            10: begin m_out = b; m_ov = 1; end
            11: m_pc = ins % 16;
            default: ;
        endcase
    endtask

    initial begin
        int  ov, total;
        bit  ok, found;
        logic [7:0] p;

        vecs[0]  = '{8'hFF, 8'h01, 8'h01, 8'h00, 1'b1};
        vecs[1]  = '{8'h00, 8'h01, 8'h11, 8'hFF, 1'b1};
        vecs[2]  = '{8'h09, 8'h00, 8'h31, 8'hFF, 1'b1};
        vecs[3]  = '{8'h03, 8'h00, 8'h51, 8'h01, 1'b1};
        vecs[4]  = '{8'h10, 8'h10, 8'h21, 8'h00, 1'b1};
        vecs[5]  = '{8'h05, 8'h07, 8'h21, 8'h23, 1'b0};
        vecs[6]  = '{8'h81, 8'h00, 8'h41, 8'h02, 1'b1};
        vecs[7]  = '{8'h33, 8'h0F, 8'h61, 8'hE1, 1'b0};
        vecs[8]  = '{8'h09, 8'h02, 8'h31, 8'h04, 1'b0};
        vecs[9]  = '{8'h05, 8'h03, 8'h11, 8'h02, 1'b0};
        vecs[10] = '{8'h01, 8'h5A, 8'h71, 8'h5A, 1'b0};
        vecs[11] = '{8'h01, 8'h20, 8'h61, 8'h00, 1'b1};

        // clock/reset
        reset_n = 1'b0; run = 1'b0; step = 1'b0; restart = 1'b0;
        in_a = 8'h00; in_b = 8'h00;
        clear_rom();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_pc", 32'(pc), 32'd0);
        reset_n = 1'b1;

        // asynchronous reset in the middle of EXEC while free-running
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state == 2'd2 && pc >= 8'd3) begin found = 1'b1; break; end
        end
        check("reach_exec", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_pc", 32'(pc), 32'd0);
        check("async_outs", {out_data, 5'd0, out_valid, carry, halted}, 32'd0);
        run = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", 32'(state), 32'd0);
        check("post_reset_pc", 32'(pc), 32'd0);

        // stepped area program
        rom[0] = 8'h80; rom[1] = 8'h94; rom[2] = 8'h21; rom[3] = 8'hA0; rom[4] = 8'hF0;
        in_a = 8'd5; in_b = 8'd7;
        total = 0;
        for (int i = 0; i < 5; i++) begin
            step_one(ov, ok);
            total += ov;
            check("area_step_done", 32'(ok), 32'd1);
            repeat (1) @(posedge clk);
        end
        check("area_out", 32'(out_data), 32'h23);
        check("area_ov_pulses", 32'(total), 32'd1);
        check("area_halted", 32'(halted), 32'd1);
        check("area_pc", 32'(pc), 32'd5);
        check("area_state", 32'(state), 32'd3);
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        repeat (4) @(negedge clk);
        check("halt_ignores_step_pc", 32'(pc), 32'd5);
        check("halt_ignores_step_st", 32'(state), 32'd3);

        // restart from HALT, then free-run from address 0
        restart_core();
        @(negedge clk);
        check("restart_pc", 32'(pc), 32'd0);
        check("restart_state", 32'(state), 32'd0);
        check("restart_flags", {out_data, 6'd0, carry, halted}, 32'd0);
        rom[0] = 8'hA1; rom[1] = 8'hF0;
        run = 1'b1;
        total = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) total++;
            if (halted === 1'b1) begin found = 1'b1; break; end
        end
        run = 1'b0;
        check("rerun_halted", 32'(found), 32'd1);
        check("rerun_regs_cleared", 32'(out_data), 32'd0);
        check("rerun_ov", 32'(total), 32'd1);
        check("rerun_pc", 32'(pc), 32'd2);

        // JMP then fetch from the target
        restart_core();
        clear_rom();
        rom[0] = 8'hBF; rom[8'h0F] = 8'h80; rom[8'h10] = 8'hA0;
        in_a = 8'h77;
        step_one(ov, ok);
        check("jmp_pc", 32'(pc), 32'h0F);
        step_one(ov, ok);
        step_one(ov, ok);
        check("jmp_target_exec", 32'(out_data), 32'h77);
        check("jmp_target_pc", 32'(pc), 32'h11);

        // step during FETCH is dropped
        restart_core();
        clear_rom();
        rom[0] = 8'h80; rom[1] = 8'hA0;
        in_a = 8'h3C;
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        total = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) total++;
        end
        check("drop_pc", 32'(pc), 32'd1);
        check("drop_state", 32'(state), 32'd0);
        check("drop_no_out", 32'(total), 32'd0);
        step_one(ov, ok);
        check("drop_next_out", 32'(out_data), 32'h3C);
        check("drop_next_ov", 32'(ov), 32'd1);

        // ALU vector table
        for (int k = 0; k < 12; k++) begin
            restart_core();
            clear_rom();
            rom[0] = 8'h80; rom[1] = 8'h94; rom[2] = vecs[k].op_instr; rom[3] = 8'hA0;
            in_a = vecs[k].a;
            in_b = vecs[k].b;
            for (int i = 0; i < 4; i++) step_one(ov, ok);
            check($sformatf("alu[%0d]_y", k), 32'(out_data), 32'(vecs[k].exp_y));
            check($sformatf("alu[%0d]_c", k), 32'(carry), 32'(vecs[k].exp_c));
        end

        // free-run PC wrap, then drop run mid-instruction
        restart_core();
        clear_rom();
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (pc == 8'hFF) begin found = 1'b1; break; end
        end
        check("wrap_reach_ff", 32'(found), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pc != 8'hFF) begin found = 1'b1; break; end
        end
        check("wrap_pc", {31'd0, found} + 32'(pc), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (state == 2'd1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        p = pc;
        run = 1'b0;
        check("rundrop_in_fetch", 32'(found), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (state == 2'd0) begin found = 1'b1; break; end
        end
        check("rundrop_idle", 32'(found), 32'd1);
        check("rundrop_pc", 32'(pc), 32'(p + 8'd1));

        // randomized program vs model
        restart_core();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'($urandom_range(0, 255));
            if (rom[i][7:4] == 4'hF) rom[i][7:4] = 4'hC;
        end
        model_reset();
        for (int n = 0; n < 150; n++) begin
            in_a = 8'($urandom_range(0, 255));
            in_b = 8'($urandom_range(0, 255));
            model_step(int'(in_a), int'(in_b));
            step_one(ov, ok);
            check("rnd_done", 32'(ok), 32'd1);
            check("rnd_pc", 32'(pc), 32'(m_pc));
            check("rnd_out", 32'(out_data), 32'(m_out));
            check("rnd_carry", 32'(carry), 32'(m_carry));
            check("rnd_ov", 32'(ov), 32'(m_ov));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
